// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-SRAM arbiter (optional debug aging: SRAM_ARB_AGE_EN).
package dmem_arb_pkg;

    localparam int unsigned WORD_AW = 14;
    localparam int unsigned DW      = 32;
    localparam int unsigned BEW     = 4;

    typedef enum logic [1:0] {
        S_CORE = 2'd0,
        S_DBG  = 2'd1,
        S_YLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // One SRAM beat minus the address (address width follows the AW parameter).
    typedef struct packed {
        logic [BEW-1:0] we;
        logic [DW-1:0]  wd;
        logic [BEW-1:0] re;
    } beat_t;

endpackage

// File: rtl/dmem_arb_age.sv
// Saturating debug-wait counter; raises aged_o once debug has waited AGE_MAX ungranted cycles.
module dmem_arb_age #(
    parameter int unsigned AGE_MAX = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic req_i,
    input  logic gnt_i,
    output logic aged_o
);

    localparam int unsigned CW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

    logic [CW-1:0] age_q;
    logic [CW-1:0] age_d;

    always_comb begin
        age_d = age_q;
        if (gnt_i) begin
            age_d = '0;
        end else if (req_i && (age_q != CW'(AGE_MAX))) begin
            age_d = age_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign aged_o = (age_q == CW'(AGE_MAX));

endmodule

// File: rtl/dmem_arb.sv
// Core/debug arbiter for the single-port data SRAM with bounded debug bursts and a forced core yield.
// Define SRAM_ARB_AGE_EN to let a long-waiting debug request pre-empt an active core.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = 16,
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned AGE_MAX   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] c_a,
    input  logic [3:0]    c_we,
    input  logic [31:0]   c_wd,
    input  logic [3:0]    c_re,
    output logic [31:0]   c_rd,
    output logic          c_stall,
    input  logic          d_req,
    input  logic [AW-1:0] d_a,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_wd,
    input  logic [3:0]    d_re,
    output logic          d_gnt,
    output logic [31:0]   d_rd,
    output logic          d_rvld,
    output logic [AW-3:0] m_a,
    output logic [3:0]    m_we,
    output logic [31:0]   m_wd,
    output logic [3:0]    m_re,
    input  logic [31:0]   m_rd
);

    localparam int unsigned BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] beat_inc;
    owner_e        own_q, own_d;
    logic          rd_q, rd_d;

    logic  core_act;
    logic  dbg_win;
    logic  core_win;
    logic  aged;
    beat_t c_beat, d_beat, m_beat;

    assign core_act = |(c_we | c_re);
    assign c_beat   = {c_we, c_wd, c_re};
    assign d_beat   = {d_we, d_wd, d_re};

`ifdef SRAM_ARB_AGE_EN
    dmem_arb_age #(
        .AGE_MAX (AGE_MAX)
    ) u_age (
        .clk    (clk),
        .rstn   (rstn),
        .req_i  (d_req),
        .gnt_i  (d_gnt),
        .aged_o (aged)
    );
`else
    logic unused_age;
    assign aged       = 1'b0;
    assign unused_age = (AGE_MAX != 0);
`endif

    // Address bits [1:0] select a byte lane only via the enables.
    logic unused_lsb;
    assign unused_lsb = ^{c_a[1:0], d_a[1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_CORE;
            beat_q  <= '0;
            own_q   <= OWN_NONE;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            own_q   <= own_d;
            rd_q    <= rd_d;
        end
    end

    // Winner selection, burst accounting and next state.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        dbg_win  = 1'b0;
        beat_inc = (state_q == S_DBG) ? (beat_q + BW'(1)) : BW'(1);

        case (state_q)
            S_CORE:  dbg_win = d_req && (!core_act || aged);
            S_DBG:   dbg_win = d_req;
            S_YLD:   dbg_win = 1'b0;
            default: dbg_win = 1'b0;
        endcase
        if (!rstn) begin
            dbg_win = 1'b0;
        end

        if (dbg_win) begin
            if (beat_inc >= BW'(BURST_MAX)) begin
                beat_d  = '0;
                state_d = core_act ? S_YLD : S_CORE;
            end else begin
                beat_d  = beat_inc;
                state_d = S_DBG;
            end
        end else if (state_q == S_DBG) begin
            // Debug dropped its request mid-burst; still hand the core its slot.
            beat_d  = '0;
            state_d = core_act ? S_YLD : S_CORE;
        end else begin
            beat_d  = '0;
            state_d = S_CORE;
        end
    end

    // SRAM mux from the winner; the loser's enables never reach the SRAM.
    always_comb begin
        core_win = rstn && core_act && !dbg_win;
        m_beat   = '0;
        m_a      = '0;
        own_d    = OWN_NONE;
        if (dbg_win) begin
            m_beat = d_beat;
            m_a    = d_a[AW-1:2];
            own_d  = OWN_DBG;
        end else if (core_win) begin
            m_beat = c_beat;
            m_a    = c_a[AW-1:2];
            own_d  = OWN_CORE;
        end
        rd_d = |m_beat.re;
    end

    assign m_we    = m_beat.we;
    assign m_wd    = m_beat.wd;
    assign m_re    = m_beat.re;
    assign d_gnt   = dbg_win;
    assign c_stall = core_act && dbg_win;
    assign c_rd    = m_rd;
    assign d_rd    = m_rd;
    assign d_rvld  = rstn && (own_q == OWN_DBG) && rd_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed vector table, hand sequences for bursts/reset/aging, random vs. model.
`timescale 1ns/1ps
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    localparam int unsigned AW        = 16;
    localparam int unsigned BURST_MAX = 8;
    localparam int unsigned AGE_MAX   = 16;
    localparam int unsigned NRAND     = 3000;
`ifdef SRAM_ARB_AGE_EN
    localparam bit AGE_ON = 1'b1;
`else
    localparam bit AGE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] c_a, d_a;
    logic [3:0]    c_we, c_re, d_we, d_re;
    logic [31:0]   c_wd, d_wd, c_rd, d_rd, m_wd, m_rd;
    logic          c_stall, d_req, d_gnt, d_rvld;
    logic [AW-3:0] m_a;
    logic [3:0]    m_we, m_re;

    dmem_arb #(.AW(AW), .BURST_MAX(BURST_MAX), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .c_a(c_a), .c_we(c_we), .c_wd(c_wd), .c_re(c_re), .c_rd(c_rd), .c_stall(c_stall),
        .d_req(d_req), .d_a(d_a), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_gnt(d_gnt), .d_rd(d_rd), .d_rvld(d_rvld),
        .m_a(m_a), .m_we(m_we), .m_wd(m_wd), .m_re(m_re), .m_rd(m_rd)
    );

    always #5 clk = ~clk;

    // SRAM: enables/address registered at posedge, read data the following cycle.
    logic [31:0] sram [0:(1<<WORD_AW)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (m_we[b]) sram[m_a][8*b +: 8] <= m_wd[8*b +: 8];
        end
        if (|m_re) m_rd <= sram[m_a];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic drive_core(input logic [3:0] we, input logic [3:0] re,
                              input logic [15:0] a, input logic [31:0] wd);
        c_we = we; c_re = re; c_a = a; c_wd = wd;
    endtask

    task automatic drive_dbg(input logic req, input logic [3:0] we, input logic [3:0] re,
                             input logic [15:0] a, input logic [31:0] wd);
        d_req = req; d_we = we; d_re = re; d_a = a; d_wd = wd;
    endtask

    typedef struct {
        logic [3:0]  c_we, c_re;
        logic [15:0] c_a;
        logic [31:0] c_wd;
        logic        d_req;
        logic [3:0]  d_we, d_re;
        logic [15:0] d_a;
        logic [31:0] d_wd;
        logic        e_gnt, e_stall, e_rvld;
        logic [1:0]  e_sel;   // 1: check c_rd, 2: check d_rd
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] cwe, input logic [3:0] cre, input logic [15:0] ca,
                                input logic [31:0] cwd, input logic dreq, input logic [3:0] dwe,
                                input logic [3:0] dre, input logic [15:0] da, input logic [31:0] dwd,
                                input logic eg, input logic es, input logic ev,
                                input logic [1:0] sel, input logic [31:0] erd);
        vec_t v;
        v.c_we = cwe; v.c_re = cre; v.c_a = ca; v.c_wd = cwd;
        v.d_req = dreq; v.d_we = dwe; v.d_re = dre; v.d_a = da; v.d_wd = dwd;
        v.e_gnt = eg; v.e_stall = es; v.e_rvld = ev; v.e_sel = sel; v.e_rd = erd;
        return v;
    endfunction

    function automatic logic [WORD_AW-1:0] pick_word();
        logic [WORD_AW-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = 14'h3FFF;
            1:       w = 14'h2000;
            default: w = WORD_AW'($urandom_range(0, 7));
        endcase
        return w;
    endfunction

    // Reference model state for the random phase.
    logic [31:0] mm      [0:(1<<WORD_AW)-1];
    bit          written [0:(1<<WORD_AW)-1];

    vec_t vt[15];

    initial begin
        int          run, age;
        bit          yld, nyld, core_act, dwin, cwin, aged, hold_c, hold_d;
        bit          exp_cv, exp_dv;
        logic [31:0] exp_cd, exp_dd;
        logic [WORD_AW-1:0] w;

        rstn = 1'b0;
        drive_core(4'hF, 4'h0, 16'h0040, 32'h1234_5678);
        drive_dbg(1'b1, 4'h0, 4'hF, 16'h0010, 32'h0);
        repeat (3) next_cycle();

        // Reset holds everything quiet even with both sides requesting.
        settle();
        chk("rst_d_gnt",   32'(d_gnt),   32'd0);
        chk("rst_c_stall", 32'(c_stall), 32'd0);
        chk("rst_m_we",    32'(m_we),    32'd0);
        chk("rst_m_re",    32'(m_re),    32'd0);
        chk("rst_m_a",     32'(m_a),     32'd0);
        chk("rst_m_wd",    m_wd,         32'd0);
        chk("rst_d_rvld",  32'(d_rvld),  32'd0);
        next_cycle();
        drive_core(4'h0, 4'h0, 16'h0, 32'h0);
        drive_dbg(1'b0, 4'h0, 4'h0, 16'h0, 32'h0);
        rstn = 1'b1;
        next_cycle();

        vt[0]  = mk(4'hF, 4'h0, 16'h0040, 32'hDEAD_BEEF, 0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 0, 32'h0);
        vt[1]  = mk(4'h0, 4'hF, 16'h0040, 32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 0, 32'h0);
        vt[2]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 1, 32'hDEAD_BEEF);
        vt[3]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'hF, 4'h0, 16'h0000, 32'h1122_3344, 1, 0, 0, 0, 32'h0);
        vt[4]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'hF, 4'h0, 16'h0004, 32'hA5A5_0001, 1, 0, 0, 0, 32'h0);
        vt[5]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'hF, 4'h0, 16'h0008, 32'h0BAD_F00D, 1, 0, 0, 0, 32'h0);
        vt[6]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'h0, 4'hF, 16'h0000, 32'h0,      1, 0, 0, 0, 32'h0);
        vt[7]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'h0, 4'hF, 16'h0004, 32'h0,      1, 0, 1, 2, 32'h1122_3344);
        vt[8]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'h0, 4'hF, 16'h0008, 32'h0,      1, 0, 1, 2, 32'hA5A5_0001);
        vt[9]  = mk(4'h0, 4'h0, 16'h0,    32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 1, 2, 32'h0BAD_F00D);
        vt[10] = mk(4'b0100, 4'h0, 16'h0002, 32'hAAAA_AAAA, 0, 4'h0, 4'h0, 16'h0, 32'h0,      0, 0, 0, 0, 32'h0);
        vt[11] = mk(4'h0, 4'hF, 16'h0001, 32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 0, 32'h0);
        vt[12] = mk(4'h0, 4'h0, 16'h0,    32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 1, 32'h11AA_3344);
        vt[13] = mk(4'h0, 4'h0, 16'h0,    32'h0,         1, 4'h0, 4'h0, 16'h0010, 32'h0,      1, 0, 0, 0, 32'h0);
        vt[14] = mk(4'h0, 4'h0, 16'h0,    32'h0,         0, 4'h0, 4'h0, 16'h0, 32'h0,         0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive_core(vt[i].c_we, vt[i].c_re, vt[i].c_a, vt[i].c_wd);
            drive_dbg(vt[i].d_req, vt[i].d_we, vt[i].d_re, vt[i].d_a, vt[i].d_wd);
            settle();
            chk($sformatf("vec%0d_d_gnt", i),   32'(d_gnt),   32'(vt[i].e_gnt));
            chk($sformatf("vec%0d_c_stall", i), 32'(c_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_d_rvld", i),  32'(d_rvld),  32'(vt[i].e_rvld));
            if (vt[i].e_sel == 2'd1) chk($sformatf("vec%0d_c_rd", i), c_rd, vt[i].e_rd);
            if (vt[i].e_sel == 2'd2) chk($sformatf("vec%0d_d_rd", i), d_rd, vt[i].e_rd);
            next_cycle();
        end

        // Contention: core reads back-to-back, debug only gets in when the core idles.
        drive_core(4'h0, 4'hF, 16'h0040, 32'h0);
        drive_dbg(1'b1, 4'h0, 4'hF, 16'h0004, 32'h0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("cont_wait_gnt", 32'(d_gnt), 32'd0);
            chk("cont_wait_stall", 32'(c_stall), 32'd0);
            if (k > 0) chk("cont_wait_c_rd", c_rd, 32'hDEAD_BEEF);
            next_cycle();
        end
        drive_core(4'h0, 4'h0, 16'h0040, 32'h0);
        settle();
        chk("cont_beat1_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        drive_core(4'h0, 4'hF, 16'h0040, 32'h0);
        for (int k = 2; k <= int'(BURST_MAX); k++) begin
            settle();
            chk($sformatf("cont_beat%0d_gnt", k), 32'(d_gnt), 32'd1);
            chk($sformatf("cont_beat%0d_stall", k), 32'(c_stall), 32'd1);
            chk($sformatf("cont_beat%0d_d_rd", k), d_rd, 32'hA5A5_0001);
            next_cycle();
        end
        settle();
        chk("cont_yield_gnt", 32'(d_gnt), 32'd0);
        chk("cont_yield_stall", 32'(c_stall), 32'd0);
        chk("cont_yield_rvld", 32'(d_rvld), 32'd1);
        chk("cont_yield_m_re", 32'(m_re), 32'hF);
        next_cycle();
        settle();
        chk("cont_post_gnt", 32'(d_gnt), 32'd0);
        chk("cont_post_stall", 32'(c_stall), 32'd0);
        chk("cont_post_rvld", 32'(d_rvld), 32'd0);
        chk("cont_post_c_rd", c_rd, 32'hDEAD_BEEF);
        next_cycle();
        drive_core(4'h0, 4'h0, 16'h0, 32'h0);
        settle();
        chk("cont_idle_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        drive_dbg(1'b0, 4'h0, 4'h0, 16'h0, 32'h0);
        next_cycle();

        // Reset mid-burst with a debug read in flight.
        drive_dbg(1'b1, 4'h0, 4'hF, 16'h0008, 32'h0);
        settle();
        chk("rmb_beat1_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        settle();
        chk("rmb_beat2_gnt", 32'(d_gnt), 32'd1);
        chk("rmb_beat2_rvld", 32'(d_rvld), 32'd1);
        chk("rmb_beat2_d_rd", d_rd, 32'h0BAD_F00D);
        next_cycle();
        rstn = 1'b0;
        settle();
        chk("rmb_rst_gnt", 32'(d_gnt), 32'd0);
        chk("rmb_rst_rvld", 32'(d_rvld), 32'd0);
        chk("rmb_rst_m_re", 32'(m_re), 32'd0);
        next_cycle();
        rstn = 1'b1;
        drive_core(4'h0, 4'hF, 16'h0040, 32'h0);
        settle();
        chk("rmb_after_rvld", 32'(d_rvld), 32'd0);
        chk("rmb_after_gnt", 32'(d_gnt), 32'd0);
        chk("rmb_after_stall", 32'(c_stall), 32'd0);
        chk("rmb_after_m_re", 32'(m_re), 32'hF);
        next_cycle();
        drive_core(4'h0, 4'h0, 16'h0, 32'h0);
        settle();
        chk("rmb_core_c_rd", c_rd, 32'hDEAD_BEEF);
        chk("rmb_dbg_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        drive_dbg(1'b0, 4'h0, 4'h0, 16'h0, 32'h0);
        settle();
        chk("rmb_dbg_d_rd", d_rd, 32'h0BAD_F00D);
        next_cycle();

`ifdef SRAM_ARB_AGE_EN
        // Aging: a continuously busy core yields after AGE_MAX ungranted debug cycles.
        drive_core(4'h0, 4'hF, 16'h0040, 32'h0);
        drive_dbg(1'b1, 4'h0, 4'h0, 16'h0, 32'h0);
        for (int k = 1; k <= int'(AGE_MAX) + 1; k++) begin
            settle();
            chk($sformatf("age_cyc%0d_gnt", k), 32'(d_gnt), (k == int'(AGE_MAX) + 1) ? 32'd1 : 32'd0);
            chk($sformatf("age_cyc%0d_stall", k), 32'(c_stall), (k == int'(AGE_MAX) + 1) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive_dbg(1'b0, 4'h0, 4'h0, 16'h0, 32'h0);
        next_cycle();
        drive_core(4'h0, 4'h0, 16'h0, 32'h0);
        next_cycle();
        next_cycle();
`endif

        // Random traffic against the reference model, from a fresh reset.
        rstn = 1'b0;
        drive_core(4'h0, 4'h0, 16'h0, 32'h0);
        drive_dbg(1'b0, 4'h0, 4'h0, 16'h0, 32'h0);
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < (1 << WORD_AW); i++) written[i] = 1'b0;
        run = 0; yld = 1'b0; age = 0; hold_c = 1'b0; hold_d = 1'b0;
        exp_cv = 1'b0; exp_dv = 1'b0; exp_cd = '0; exp_dd = '0;

        for (int n = 0; n < int'(NRAND); n++) begin
            if (!hold_c) begin
                w = pick_word();
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: drive_core(4'h0, 4'h0, {w, 2'($urandom_range(0, 3))}, $urandom);
                    4, 5, 6:    drive_core(4'($urandom_range(1, 15)), 4'h0, {w, 2'($urandom_range(0, 3))}, $urandom);
                    default: begin
                        if (written[w]) drive_core(4'h0, 4'($urandom_range(1, 15)), {w, 2'($urandom_range(0, 3))}, $urandom);
                        else            drive_core(4'hF, 4'h0, {w, 2'($urandom_range(0, 3))}, $urandom);
                    end
                endcase
            end
            if (!hold_d) begin
                w = pick_word();
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: drive_dbg(1'b0, 4'h0, 4'h0, {w, 2'b00}, $urandom);
                    4, 5, 6:    drive_dbg(1'b1, 4'($urandom_range(1, 15)), 4'h0, {w, 2'($urandom_range(0, 3))}, $urandom);
                    7:          drive_dbg(1'b1, 4'h0, 4'h0, {w, 2'b00}, $urandom);
                    default: begin
                        if (written[w]) drive_dbg(1'b1, 4'h0, 4'($urandom_range(1, 15)), {w, 2'b00}, $urandom);
                        else            drive_dbg(1'b1, 4'hF, 4'h0, {w, 2'b00}, $urandom);
                    end
                endcase
            end
            settle();

            chk("rnd_d_rvld", 32'(d_rvld), 32'(exp_dv));
            if (exp_dv) chk("rnd_d_rd", d_rd, exp_dd);
            if (exp_cv) chk("rnd_c_rd", c_rd, exp_cd);

            // Core priority, BURST_MAX-beat debug bursts, one core slot after a contended burst.
            core_act = (c_we | c_re) != 4'h0;
            aged     = AGE_ON && (age == int'(AGE_MAX));
            if (yld)          dwin = 1'b0;
            else if (run > 0) dwin = d_req;
            else              dwin = d_req && (!core_act || aged);
            cwin = core_act && !dwin;
            chk("rnd_d_gnt", 32'(d_gnt), 32'(dwin));
            chk("rnd_c_stall", 32'(c_stall), 32'(core_act && dwin));

            nyld = 1'b0;
            if (dwin) begin
                run++;
                if (run >= int'(BURST_MAX)) begin
                    run  = 0;
                    nyld = core_act;
                end
            end else if (run > 0) begin
                run  = 0;
                nyld = core_act;
            end
            yld = nyld;
            if (dwin) age = 0;
            else if (d_req && age < int'(AGE_MAX)) age++;

            exp_cv = cwin && (c_re != 4'h0);
            exp_dv = dwin && (d_re != 4'h0);
            if (exp_cv) exp_cd = mm[c_a[AW-1:2]];
            if (exp_dv) exp_dd = mm[d_a[AW-1:2]];
            if (cwin) begin
                for (int b = 0; b < 4; b++) if (c_we[b]) mm[c_a[AW-1:2]][8*b +: 8] = c_wd[8*b +: 8];
                if (c_we == 4'hF) written[c_a[AW-1:2]] = 1'b1;
            end
            if (dwin) begin
                for (int b = 0; b < 4; b++) if (d_we[b]) mm[d_a[AW-1:2]][8*b +: 8] = d_wd[8*b +: 8];
                if (d_we == 4'hF) written[d_a[AW-1:2]] = 1'b1;
            end

            hold_c = core_act && dwin;
            hold_d = d_req && !dwin;
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
